bitty_exec_ctrl: RTL and testbench

- Multi-cycle execute controller that sits directly upstream of the 16-bit ALU and also consumes its result.
- Accepts one 16-bit instruction at a time via a valid/ready handshake.
- Reads operands from an internal 8x16 register file and drives the ALU's operand, select, mode and carry_in pins.
- Latches carry_out, compare and alu_out, then writes the result back to the destination register and updates the carry and compare flags.

---
 rtl/bitty_exec_ctrl.sv | 127 ++++++++++++
 tb/tb_bitty_exec_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bitty_exec_ctrl.sv
// Multi-cycle execute controller for the 16-bit ALU: fetches operands from an
// internal register file, drives the ALU, latches its result and writes back.
module bitty_exec_ctrl #(
  parameter int NREGS = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [15:0]              instr,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [3:0]               alu_select,
  output logic                     alu_mode,
  output logic                     alu_carry_in,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic                     alu_carry_out,
  input  logic                     alu_compare,
  output logic                     carry_flag,
  output logic                     compare_flag,
  output logic                     done,
  output logic                     illegal,
  input  logic [$clog2(NREGS)-1:0] dbg_sel,
  output logic [WIDTH-1:0]         dbg_data
);

  localparam int IW = $clog2(NREGS);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t           state;
  logic [15:0]      ir;
  logic [WIDTH-1:0] rf [NREGS];
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       op_sel;
  logic             op_mode;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_cmp;
  logic             ready_q;
  logic             done_q;
  logic             illegal_q;
  logic             carry_q;
  logic             cmp_q;

  logic [IW-1:0]    rx;
  logic [IW-1:0]    ry;
  logic [1:0]       fmt;
  logic [WIDTH-1:0] imm;

  assign rx  = ir[15 -: IW];
  assign ry  = ir[12 -: IW];
  assign fmt = ir[1:0];
  assign imm = WIDTH'(ir[12:7]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ir        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_sel    <= '0;
      op_mode   <= 1'b0;
      res       <= '0;
      res_c     <= 1'b0;
      res_cmp   <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      carry_q   <= 1'b0;
      cmp_q     <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (instr_valid) begin
            ir      <= instr;
            ready_q <= 1'b0;
            state   <= S_READ;
          end
        end
        S_READ: begin
          op_a    <= rf[rx];
          op_b    <= (fmt == 2'b01) ? imm : rf[ry];
          op_sel  <= ir[5:2];
          op_mode <= ir[6];
          state   <= S_EXEC;
        end
        S_EXEC: begin
          res       <= alu_out;
          res_c     <= alu_carry_out;
          res_cmp   <= alu_compare;
          done_q    <= 1'b1;
          illegal_q <= (fmt == 2'b11);
          state     <= S_WB;
        end
        S_WB: begin
          if (fmt != 2'b11) begin
            carry_q <= res_c;
            cmp_q   <= res_cmp;
          end
          // Formats 00 and 01 write back; 10 and 11 leave the file untouched
          if (!fmt[1]) rf[rx] <= res;
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
          ready_q   <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready  = ready_q;
  assign alu_a        = op_a;
  assign alu_b        = op_b;
  assign alu_select   = op_sel;
  assign alu_mode     = op_mode;
  assign alu_carry_in = carry_q;
  assign carry_flag   = carry_q;
  assign compare_flag = cmp_q;
  assign done         = done_q;
  assign illegal      = illegal_q;
  assign dbg_data     = rf[dbg_sel];

endmodule

// File: tb/tb_bitty_exec_ctrl.sv
// Bench for bitty_exec_ctrl: a transaction-level model predicts every output
// each cycle; directed instructions carry hand-computed ALU responses.
module tb_bitty_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_select;
  logic        alu_mode;
  logic        alu_carry_in;
  logic [15:0] alu_out = '0;
  logic        alu_carry_out = 1'b0;
  logic        alu_compare = 1'b0;
  logic        carry_flag;
  logic        compare_flag;
  logic        done;
  logic        illegal;
  logic [2:0]  dbg_sel = '0;
  logic [15:0] dbg_data;

  int n_checks = 0;
  int n_err = 0;

  bitty_exec_ctrl #(.NREGS(8), .WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_select(alu_select), .alu_mode(alu_mode), .alu_carry_in(alu_carry_in),
    .alu_out(alu_out), .alu_carry_out(alu_carry_out), .alu_compare(alu_compare),
    .carry_flag(carry_flag), .compare_flag(compare_flag), .done(done),
    .illegal(illegal), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Architectural model: registers, flags, and the single in-flight instruction
  // tracked by the number of edges since it was accepted.
  logic [15:0] m_rf [8];
  logic        m_c, m_cmp, m_busy;
  int          m_k;
  int          m_accepts = 0;
  logic [15:0] m_ir, m_pa, m_pb, m_res;
  logic        m_rc, m_rcmp;
  logic [15:0] m_a, m_b;
  logic [3:0]  m_sel;
  logic        m_mode;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
      m_c = 1'b0; m_cmp = 1'b0; m_busy = 1'b0; m_k = 0;
      m_ir = '0; m_pa = '0; m_pb = '0; m_res = '0; m_rc = 1'b0; m_rcmp = 1'b0;
      m_a = '0; m_b = '0; m_sel = '0; m_mode = 1'b0;
    end else if (!m_busy) begin
      if (instr_valid) begin
        m_ir = instr;
        m_pa = m_rf[instr[15:13]];
        m_pb = (instr[1:0] == 2'b01) ? {10'b0, instr[12:7]} : m_rf[instr[12:10]];
        m_busy = 1'b1;
        m_k = 1;
        m_accepts++;
      end
    end else begin
      m_k++;
      case (m_k)
        2: begin
          m_a = m_pa; m_b = m_pb; m_sel = m_ir[5:2]; m_mode = m_ir[6];
        end
        3: begin
          m_res = alu_out; m_rc = alu_carry_out; m_rcmp = alu_compare;
        end
        default: begin
          if (m_ir[1:0] != 2'b11) begin
            m_c = m_rc; m_cmp = m_rcmp;
          end
          if (m_ir[1] == 1'b0) m_rf[m_ir[15:13]] = m_res;
          m_busy = 1'b0;
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model; dbg_sel walks all registers.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("instr_ready",  16'(instr_ready),  16'(!m_busy));
      chk("done",         16'(done),         16'(m_busy && m_k == 3));
      chk("illegal",      16'(illegal),      16'(m_busy && m_k == 3 && m_ir[1:0] == 2'b11));
      chk("carry_flag",   16'(carry_flag),   16'(m_c));
      chk("compare_flag", 16'(compare_flag), 16'(m_cmp));
      chk("alu_carry_in", 16'(alu_carry_in), 16'(m_c));
      chk("alu_a",        alu_a,             m_a);
      chk("alu_b",        alu_b,             m_b);
      chk("alu_select",   16'(alu_select),   16'(m_sel));
      chk("alu_mode",     16'(alu_mode),     16'(m_mode));
      chk("dbg_data",     dbg_data,          m_rf[dbg_sel]);
      dbg_sel = dbg_sel + 3'd1;
    end
  end

  task automatic wait_accept();
    int start = m_accepts;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (m_accepts != start) return;
    end
    n_checks++; n_err++;
    $display("FAIL accept_timeout: got no acceptance required one within 40 cycles");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!m_busy) return;
    end
    n_checks++; n_err++;
    $display("FAIL idle_timeout: got busy required idle within 40 cycles");
  endtask

  // Returns one time unit after the acceptance edge with instr_valid dropped.
  task automatic run(input logic [15:0] ins, input logic [15:0] r, input logic c, input logic k);
    alu_out = r; alu_carry_out = c; alu_compare = k;
    instr = ins; instr_valid = 1'b1;
    wait_accept();
    instr_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (9) @(negedge clk);
    chk("rst_ready", 16'(instr_ready), 16'h0001);
    chk("rst_done",  16'(done),        16'h0000);
    chk("rst_carry", 16'(carry_flag),  16'h0000);

    // R3 <- imm 0x2A, mode 1, select 0101; ALU answers 0x002A carry 1
    run(16'h7555, 16'h002A, 1'b1, 1'b0);
    chk("imm_ready_low", 16'(instr_ready), 16'h0000);
    @(negedge clk);
    @(negedge clk);
    chk("imm_alu_b",   alu_b,             16'h002A);
    chk("imm_alu_sel", 16'(alu_select),   16'h0005);
    chk("imm_alu_mode",16'(alu_mode),     16'h0001);
    chk("imm_no_done", 16'(done),         16'h0000);
    @(negedge clk);
    chk("imm_done",    16'(done),         16'h0001);
    @(negedge clk);
    chk("imm_carry",   16'(carry_flag),   16'h0001);
    chk("imm_ready",   16'(instr_ready),  16'h0001);
    chk("model_r3",    m_rf[3],           16'h002A);

    // R1 <- 5, R2 <- 7 (carry left at 1), then R1 <- R1 op R2
    run(16'h2281, 16'h0005, 1'b1, 1'b0);
    wait_idle();
    run(16'h4381, 16'h0007, 1'b1, 1'b0);
    wait_idle();
    run(16'h2800, 16'h000D, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rr_alu_a",   alu_a,             16'h0005);
    chk("rr_alu_b",   alu_b,             16'h0007);
    chk("rr_cin",     16'(alu_carry_in), 16'h0001);
    @(negedge clk);
    @(negedge clk);
    chk("rr_carry",   16'(carry_flag),   16'h0000);
    chk("model_r1",   m_rf[1],           16'h000D);

    // Compare-only R4 vs R4: flags update, no write
    run(16'h9002, 16'hBEEF, 1'b1, 1'b1);
    wait_idle();
    chk("cmp_flag",   16'(compare_flag), 16'h0001);
    chk("cmp_carry",  16'(carry_flag),   16'h0001);
    chk("model_r4",   m_rf[4],           16'h0000);

    // Illegal format: pulse only, nothing architectural changes
    run(16'h6003, 16'hFFFF, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("ill_done",   16'(done),         16'h0001);
    chk("ill_pulse",  16'(illegal),      16'h0001);
    @(negedge clk);
    chk("ill_clear",  16'(illegal),      16'h0000);
    chk("ill_cmp",    16'(compare_flag), 16'h0001);
    chk("ill_carry",  16'(carry_flag),   16'h0001);
    chk("model_r3b",  m_rf[3],           16'h002A);

    // Valid held high while busy with changing words; only boundary words run
    alu_out = 16'h0011; alu_carry_out = 1'b0; alu_compare = 1'b0;
    instr = 16'hC881; instr_valid = 1'b1;
    wait_accept();
    instr = 16'h2E05;
    @(posedge clk); #1 instr = 16'h5C0A;
    @(posedge clk); #1 instr = 16'hF800; alu_out = 16'h0022;
    wait_accept();
    instr_valid = 1'b0;
    wait_idle();
    chk("model_r6",   m_rf[6],           16'h0011);
    chk("model_r7",   m_rf[7],           16'h0022);
    chk("model_r1b",  m_rf[1],           16'h000D);
    repeat (8) @(negedge clk);

    // Reset during EXEC of a write to R5 aborts without done or write
    run(16'hA001, 16'h1234, 1'b1, 1'b1);
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_done", 16'(done),         16'h0000);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready",16'(instr_ready),  16'h0001);
    chk("abort_done2",16'(done),         16'h0000);
    chk("abort_carry",16'(carry_flag),   16'h0000);
    chk("model_r5",   m_rf[5],           16'h0000);
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
